ctr_run_scheduler: RTL and testbench

CTR_RUN_SCHEDULER -- requirements
Module: ctr_run_scheduler

---
 rtl/ctr_run_scheduler.sv | 121 ++++++++++++
 tb/tb_ctr_run_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ctr_run_scheduler.sv
// ctr_run_scheduler: round-robin arbiter that runs one external counter job at a time and reports its cycle count
// Ports:
//   clk, reset_l            clock and asynchronous active-low reset
//   req_valid/req_max       per-requester run request and counter target
//   req_ready               one-hot accept for the round-robin winner (IDLE only)
//   cnt_reset_l/cnt_max     synchronous clear and target driven to the counter
//   cnt_done                counter reached target (looked at only while running)
//   cmp_valid/cmp_ready     completion handshake carrying cmp_id, cmp_cycles, cmp_timeout
//   busy                    high whenever a job is in progress or awaiting report
module ctr_run_scheduler #(
    parameter int MAX_WIDTH  = 32,
    parameter int NUM_REQ    = 4,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1000
) (
    input  logic                           clk,
    input  logic                           reset_l,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*MAX_WIDTH-1:0]   req_max,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cnt_reset_l,
    output logic [MAX_WIDTH-1:0]           cnt_max,
    input  logic                           cnt_done,
    output logic                           cmp_valid,
    input  logic                           cmp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     cmp_id,
    output logic [MAX_WIDTH:0]             cmp_cycles,
    output logic                           cmp_timeout,
    output logic                           busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CLR_CYCLES) + 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [MAX_WIDTH:0] TO_LIM = (MAX_WIDTH + 1)'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, REPORT} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_q, last_d, id_q, id_d, win, idx;
    logic [MAX_WIDTH-1:0] max_q, max_d;
    logic [MAX_WIDTH:0]   cyc_q, cyc_d;
    logic [CW-1:0]        clr_q, clr_d;
    logic                 to_q, to_d, found;

    // search starts just after the previous winner so every requester gets a turn
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        max_d   = max_q;
        cyc_d   = cyc_q;
        clr_d   = clr_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = CLEAR;
                last_d  = win;
                id_d    = win;
                max_d   = req_max[win*MAX_WIDTH +: MAX_WIDTH];
                clr_d   = '0;
            end
            CLEAR: begin
                clr_d = clr_q + 1'b1;
                cyc_d = (MAX_WIDTH + 1)'(1);
                to_d  = 1'b0;
                if (clr_q == CLR_LAST) state_d = RUN;
            end
            // done wins over the watchdog when both land on the same cycle
            RUN: if (cnt_done) state_d = REPORT;
                 else if (cyc_q == TO_LIM) begin
                     to_d    = 1'b1;
                     state_d = REPORT;
                 end else cyc_d = cyc_q + 1'b1;
            REPORT: if (cmp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            id_q    <= '0;
            max_q   <= '0;
            cyc_q   <= '0;
            clr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            max_q   <= max_d;
            cyc_q   <= cyc_d;
            clr_q   <= clr_d;
            to_q    <= to_d;
        end
    end

    // the grant is combinational, so it is masked while reset is asserted
    assign req_ready   = (state_q == IDLE && found && reset_l) ? NUM_REQ'(1) << win : '0;
    assign cnt_reset_l = state_q == RUN;
    assign cmp_valid   = state_q == REPORT;
    assign busy        = state_q != IDLE;
    assign cnt_max     = max_q;
    assign cmp_id      = id_q;
    assign cmp_cycles  = cyc_q;
    assign cmp_timeout = to_q;
endmodule

// File: tb/tb_ctr_run_scheduler.sv
// tb_ctr_run_scheduler: randomized and directed bench for ctr_run_scheduler against a transaction-level timing model
module tb_ctr_run_scheduler;
    localparam int MW = 32, NR = 4, CLR = 2, TMO = 1000;

    logic            clk = 0, reset_l = 0;
    logic [NR-1:0]   req_valid = '0, req_ready;
    logic [NR*MW-1:0] req_max = '0;
    logic            cnt_reset_l, cnt_done, cmp_valid, cmp_ready = 0, cmp_timeout, busy;
    logic [MW-1:0]   cnt_max, ctr;
    logic [1:0]      cmp_id;
    logic [MW:0]     cmp_cycles;
    logic            tie_low = 0, noise = 0;
    int              checks = 0, fails = 0;

    ctr_run_scheduler #(.MAX_WIDTH(MW), .NUM_REQ(NR), .CLR_CYCLES(CLR), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_l(reset_l), .req_valid(req_valid), .req_max(req_max), .req_ready(req_ready),
        .cnt_reset_l(cnt_reset_l), .cnt_max(cnt_max), .cnt_done(cnt_done), .cmp_valid(cmp_valid),
        .cmp_ready(cmp_ready), .cmp_id(cmp_id), .cmp_cycles(cmp_cycles), .cmp_timeout(cmp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // external counter: cleared while cnt_reset_l is low, flags done at ctr == cnt_max;
    // outside RUN cnt_done carries random noise that the scheduler must ignore
    always @(posedge clk) ctr <= cnt_reset_l ? ctr + 1 : '0;
    assign cnt_done = cnt_reset_l ? (!tie_low && ctr == cnt_max) : noise;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a job granted at cycle s spends cycles s+1..s+CLR clearing, then m_cyc cycles running,
    // then reports until the cycle cmp_ready is seen high
    bit      m_active = 0, m_to;
    int      m_last = NR - 1, m_start, m_id, cyc_n = 0, off, w;
    longint  m_max, m_cyc;
    logic [NR-1:0] e_ready;
    bit      in_run, in_rep;

    always @(negedge clk) begin
        cyc_n++;
        if (!reset_l) begin
            chk("rst_ctrl", {req_ready, busy, cnt_reset_l, cmp_valid, cmp_timeout, cmp_id}, '0);
            chk("rst_cnt_max", cnt_max, '0);
            chk("rst_cmp_cycles", cmp_cycles, '0);
            m_active = 0;
            m_last   = NR - 1;
        end else begin
            e_ready = '0;
            w = -1;
            if (!m_active)
                for (int k = 1; k <= NR; k++)
                    if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
            if (w >= 0) e_ready[w] = 1'b1;
            off    = cyc_n - m_start;
            in_run = m_active && off > CLR && off <= CLR + m_cyc;
            in_rep = m_active && off > CLR + m_cyc;
            chk("req_ready", req_ready, e_ready);
            chk("busy", busy, m_active);
            chk("cnt_reset_l", cnt_reset_l, in_run);
            chk("cmp_valid", cmp_valid, in_rep);
            if (m_active) begin
                chk("cnt_max", cnt_max, m_max);
                chk("cmp_id", cmp_id, m_id);
            end
            if (in_rep) begin
                chk("cmp_cycles", cmp_cycles, m_cyc);
                chk("cmp_timeout", cmp_timeout, m_to);
            end
            if (in_rep && cmp_ready) m_active = 0;
            else if (w >= 0) begin
                m_active = 1;
                m_start  = cyc_n;
                m_id     = w;
                m_last   = w;
                m_max    = longint'(req_max[w*MW +: MW]);
                m_to     = tie_low || m_max + 1 > TMO;
                m_cyc    = m_to ? TMO : m_max + 1;
            end
        end
    end

    task automatic run_one(input int i, input logic [MW-1:0] mx, output int id, output longint cyc, output bit to);
        int n;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[i] = 1'b1;
        req_max[i*MW +: MW] = mx;
        cmp_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[i] && n < 50);
        if (!req_ready[i]) chk("grant_wait", req_ready, 4'b1 << i);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmp_valid && n < 3000);
        if (!cmp_valid) chk("cmp_wait", cmp_valid, 1);
        id  = cmp_id;
        cyc = longint'(cmp_cycles);
        to  = cmp_timeout;
        @(posedge clk); #1;
    endtask

    task automatic run_chk(input string nm, input int i, input logic [MW-1:0] mx, input longint e_cyc, input bit e_to);
        int id; longint cyc; bit to;
        run_one(i, mx, id, cyc, to);
        chk({nm, "_id"}, id, i);
        chk({nm, "_cycles"}, cyc, e_cyc);
        chk({nm, "_timeout"}, to, e_to);
    endtask

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_cnt_reset_l", cnt_reset_l, 0);
        // round-robin from reset with everyone requesting
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) req_max[i*MW +: MW] = 2;
        cmp_ready = 1;
        reset_l = 1;
        foreach (order[k]) begin
            n = 0;
            do begin @(negedge clk); n++; end while (req_ready == 0 && n < 100);
            chk("rr_order", req_ready, 4'b1 << order[k]);
        end
        // completion held off for 10 cycles
        @(posedge clk); #1;
        cmp_ready = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmp_valid && n < 100);
        repeat (10) begin
            chk("hold_valid", cmp_valid, 1);
            chk("hold_ready", req_ready, 0);
            chk("hold_cnt_reset_l", cnt_reset_l, 0);
            chk("hold_cycles", cmp_cycles, 3);
            chk("hold_id", cmp_id, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        cmp_ready = 1;
        req_valid = '0;
        @(posedge clk); #1;
        run_chk("single", 0, 5, 6, 0);
        tie_low = 1;
        run_chk("watchdog", 1, 7, 1000, 1);
        tie_low = 0;
        run_chk("done_at_limit", 2, 999, 1000, 0);
        run_chk("over_limit", 3, 1000, 1000, 1);
        run_chk("max_zero", 1, 0, 1, 0);
        // reset in RUN cycle 3
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_max[2*MW +: MW] = 20;
        n = 0;
        do begin @(negedge clk); n++; end while (!cnt_reset_l && n < 50);
        chk("run_reached", cnt_reset_l, 1);
        repeat (2) @(posedge clk);
        #1;
        reset_l = 0;
        req_valid = 4'b1111;
        #1;
        chk("midrst_ctrl", {req_ready, busy, cnt_reset_l, cmp_valid, cmp_timeout, cmp_id}, '0);
        chk("midrst_cnt_max", cnt_max, 0);
        chk("midrst_cycles", cmp_cycles, 0);
        @(posedge clk); #1;
        reset_l = 1;
        @(negedge clk);
        chk("midrst_first_grant", req_ready, 4'b0001);
        // random traffic
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            req_valid = NR'($urandom);
            cmp_ready = $urandom_range(0, 3) != 0;
            noise = $urandom_range(0, 1) == 1;
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0)
                    req_max[i*MW +: MW] = ($urandom_range(0, 19) == 0) ? 995 + $urandom_range(0, 10) : $urandom_range(0, 12);
        end
        @(posedge clk); #1;
        req_valid = '0;
        cmp_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 3000);
        chk("drain_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench did not finish");
    end
endmodule
